multi_timer: RTL
================

Name: multi_timer

Overview:
- Multi-channel successor to the single loadable timer.
- NCH independent channels share one enable-driven prescaler that produces the time-unit tick.
- Each channel runs one-shot or periodic, can be retriggered while running, and reports expiry through a registered one-cycle done pulse.
- Used by receiver control logic for timeouts and periodic sampling windows.

Parameters:
- NCH, 4, number of timer channels (>=1)
- DW, 16, channel counter/target width
- PW, 8, prescaler counter width

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- en_i  in  1  base time-unit enable (single-cycle strobes)
- prescale_i  in  PW  tick divider; tick every (prescale_i+1) en_i strobes
- start_i  in  NCH  per-channel load-and-start (also retrigger)
- target_i  in  NCH*DW  per-channel target; channel k in bits [k*DW +: DW]
- periodic_i  in  NCH  per-channel mode at start: 0 one-shot, 1 periodic
- clr_i  in  NCH  per-channel stop/clear
- done_o  out  NCH  registered one-cycle expiry pulse per channel
- active_o  out  NCH  channel is ACTIVE
- irq_o  out  1  registered OR of next-cycle done_o bits (same cycle as done_o)

Behaviour:
- Reset: pre_cnt=0; every channel IDLE, count=0, target=0, mode=one-shot; done_o=0, active_o=0, irq_o=0.
- Prescaler:
  - tick = en_i && (pre_cnt >= prescale_i), combinational.
  - On en_i: pre_cnt <= tick ? 0 : pre_cnt+1.
  - The >= comparison recovers cleanly when prescale_i is lowered mid-count.
  - prescale_i=0 gives tick=en_i.
- Channel states: IDLE, ACTIVE. active_o = (state==ACTIVE).
- Priority within a channel each cycle: clr_i > start_i > tick.
- clr_i:
  - ACTIVE → IDLE and count <= 0; no done pulse, even if expiry coincides.
  - In IDLE: no effect.
- start_i, in any state:
  - target <= target slice, mode <= periodic_i, count <= 0, state <= ACTIVE.
  - Asserted in ACTIVE, this is a retrigger; a coinciding expiry is discarded (no done).
- Tick in ACTIVE (no clr/start):
  - expiry = ((count+1) mod 2^DW == target).
  - On expiry: done pulses next cycle. One-shot: → IDLE, count <= 0. Periodic: stay ACTIVE, count <= 0.
  - Otherwise count <= count+1.
- Expiry therefore occurs on exactly target ticks after start. target=0 means 2^DW ticks via natural wrap.
- Ticks are ignored in IDLE. Ticks in the start cycle are not counted.
- done_o is registered: high exactly one cycle, the cycle after the expiry tick.
  - In one-shot mode, active_o falls in that same cycle.
  - Periodic mode with target=1 and continuous ticks: done_o high every cycle, which is legal.
- Channels are fully independent. Simultaneous expiries in several channels raise several done_o bits together; irq_o=1 once.
- Reset asserted mid-operation returns all state to reset values immediately (asynchronous). No done is emitted.
- Counter arithmetic is DW-bit unsigned wrap. No other overflow case exists.

Decomposition:
- Package timer_pkg:
  - typedef enum logic {IDLE, ACTIVE} tmr_state_t
  - typedef enum logic {ONE_SHOT, PERIODIC} tmr_mode_t
- Sub-module timer_channel (parameter DW):
  - Holds state, target, mode, count and the done register.
  - Inputs: tick, start, target, periodic, clr.
- multi_timer contains the prescaler, a generate loop of NCH timer_channel instances, and the irq_o register.

Test Plan:
- NCH=4, DW=16, prescale=0, en_i held 1; ch0 start with target=5, one-shot → done_o[0] one cycle exactly 6 cycles after the start cycle; active_o[0] high 5 cycles, then 0 in the done cycle.
- prescale=2, en_i every cycle; ch1 periodic, target=3 → done_o[1] every 9 cycles, active_o[1] stays 1; clr_i[1] mid-period → active_o[1]=0, no further done.
- ch2 target=4; retrigger start_i[2] after 3 ticks → done 4 ticks after retrigger, not earlier; start on the exact expiry tick → no done that cycle.
- DW=4 ch3 target=0, en_i=1, prescale=0 → done_o[3] after 16 ticks; ch0 and ch3 set to expire same cycle → both done bits high, irq_o single-cycle 1.
- clr_i and start_i asserted together on an ACTIVE channel → IDLE, count=0; en_i low throughout an ACTIVE period → no count progress, no done.
- rst asserted while two channels ACTIVE and pre_cnt=1 → all outputs 0 immediately; after release, ticks resume counting from pre_cnt=0.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types for the multi-channel timer.
//
// tmr_state_t : channel run state (IDLE / ACTIVE)
// tmr_mode_t  : behaviour on expiry (ONE_SHOT stops, PERIODIC reloads)
package timer_pkg;

    typedef enum logic {IDLE, ACTIVE} tmr_state_t;
    typedef enum logic {ONE_SHOT, PERIODIC} tmr_mode_t;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: counts prescaler ticks from a start event until it has
// seen 'target' ticks, then raises a registered one-cycle done pulse.
//
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   tick        : time-unit tick from the shared prescaler
//   start       : load target/mode and (re)start counting
//   target      : number of ticks to expiry (0 means 2^DW via wrap)
//   periodic    : mode captured at start, 1 = reload on expiry
//   clr         : stop the channel without a done pulse
//   done        : registered expiry pulse
//   done_next   : value done will take after the next clock edge
//   active      : channel is ACTIVE
module timer_channel
    import timer_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick,
    input  logic          start,
    input  logic [DW-1:0] target,
    input  logic          periodic,
    input  logic          clr,
    output logic          done,
    output logic          done_next,
    output logic          active
);

    tmr_state_t    state;
    tmr_mode_t     mode;
    logic [DW-1:0] tgt;
    logic [DW-1:0] cnt;
    logic [DW-1:0] cnt_inc;

    // Expiry is only honoured when neither clr nor start claims the cycle,
    // so a coinciding clear or retrigger swallows the done pulse.
    always_comb begin
        cnt_inc   = cnt + DW'(1);
        done_next = 1'b0;
        if (!clr && !start && tick && (state == ACTIVE) && (cnt_inc == tgt)) begin
            done_next = 1'b1;
        end
    end

    // Channel state: clr has priority over start, start over tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            mode  <= ONE_SHOT;
            tgt   <= '0;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            done <= done_next;
            if (clr) begin
                if (state == ACTIVE) begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            end else if (start) begin
                tgt   <= target;
                mode  <= periodic ? PERIODIC : ONE_SHOT;
                cnt   <= '0;
                state <= ACTIVE;
            end else if (tick && (state == ACTIVE)) begin
                if (done_next) begin
                    cnt <= '0;
                    if (mode == ONE_SHOT) begin
                        state <= IDLE;
                    end
                end else begin
                    cnt <= cnt_inc;
                end
            end
        end
    end

    assign active = (state == ACTIVE);

endmodule

// File: rtl/multi_timer.sv
// Multi-channel timer: a shared enable-driven prescaler produces the
// time-unit tick consumed by NCH independent timer channels.
//
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   en_i        : base time-unit enable strobes
//   prescale_i  : tick every (prescale_i+1) en_i strobes
//   start_i     : per-channel load-and-start / retrigger
//   target_i    : per-channel target, channel k in [k*DW +: DW]
//   periodic_i  : per-channel mode at start (1 = periodic)
//   clr_i       : per-channel stop/clear
//   done_o      : per-channel registered expiry pulse
//   active_o    : per-channel ACTIVE flag
//   irq_o       : registered OR of the done pulses, aligned with done_o
module multi_timer
    import timer_pkg::*;
#(
    parameter int NCH = 4,
    parameter int DW  = 16,
    parameter int PW  = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en_i,
    input  logic [PW-1:0]   prescale_i,
    input  logic [NCH-1:0]  start_i,
    input  logic [NCH*DW-1:0] target_i,
    input  logic [NCH-1:0]  periodic_i,
    input  logic [NCH-1:0]  clr_i,
    output logic [NCH-1:0]  done_o,
    output logic [NCH-1:0]  active_o,
    output logic            irq_o
);

    logic [PW-1:0]  pre_cnt;
    logic           tick;
    logic [NCH-1:0] done_next;

    // Using >= rather than == lets the divider recover immediately if
    // prescale_i is lowered below the current count.
    assign tick = en_i && (pre_cnt >= prescale_i);

    // Prescaler advances only on enable strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt <= '0;
        end else if (en_i) begin
            pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        timer_channel #(
            .DW(DW)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .tick      (tick),
            .start     (start_i[k]),
            .target    (target_i[k*DW +: DW]),
            .periodic  (periodic_i[k]),
            .clr       (clr_i[k]),
            .done      (done_o[k]),
            .done_next (done_next[k]),
            .active    (active_o[k])
        );
    end

    // Built from the channels' next done values so it lines up with done_o.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_o <= 1'b0;
        end else begin
            irq_o <= |done_next;
        end
    end

endmodule
